// File: rtl/ghost_move_sched.sv
// Ghost motion scheduler: a score-dependent period counter starts a round-robin move sweep in vblank.
// Define GHOST_FACE_TIMER_EN to build the shared face-tile timer; otherwise face_sel is tied low.
module ghost_move_sched #(
    parameter int N_GHOSTS    = 4,
    parameter int TIME_MAX    = 4600000,
    parameter int MIN_PERIOD  = 100000,
    parameter int FACE_PERIOD = 20000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [25:0]         speed_offset,
    input  logic                vblank,
    input  logic [N_GHOSTS-1:0] chase_ok,
    input  logic [N_GHOSTS-1:0] move_ack,
    input  logic                clr_overrun,
    output logic [N_GHOSTS-1:0] move_req,
    output logic                busy,
    output logic                overrun,
    output logic                face_sel
);
    localparam int                IW         = (N_GHOSTS > 1) ? $clog2(N_GHOSTS) : 1;
    localparam logic [26:0]       TIME_MAX_W = 27'(TIME_MAX);
    localparam logic [26:0]       MIN_PER_W  = 27'(MIN_PERIOD);
    localparam logic [26:0]       CLAMP_AT   = 27'(TIME_MAX - MIN_PERIOD);
    localparam logic [IW-1:0]     LAST_IDX   = IW'(N_GHOSTS - 1);
    localparam logic [N_GHOSTS-1:0] ONE      = N_GHOSTS'(1);

    if (N_GHOSTS < 2 || N_GHOSTS > 8 || TIME_MAX >= 2**26 || 2*FACE_PERIOD > 2**26) begin : g_bad_params
        $error("ghost_move_sched: parameters out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [25:0]   cnt;
    logic          pending;
    logic [26:0]   offset_w;
    logic [26:0]   period;
    logic          tick;
    logic          last;

    // 27-bit arithmetic so a large offset clamps instead of wrapping.
    always_comb begin
        offset_w = {1'b0, speed_offset};
        period   = (offset_w >= CLAMP_AT) ? MIN_PER_W : (TIME_MAX_W - offset_w);
        tick     = enable && ({1'b0, cnt} >= period);
    end

    assign busy = (state != IDLE);
    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (!enable || tick)
            cnt <= '0;
        else
            cnt <= cnt + 26'd1;
    end

    // A tick only arms pending when nothing is queued or running; otherwise it is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (tick && (pending || busy))
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;

            if (!enable)
                pending <= 1'b0;
            else if (tick && !pending && !busy)
                pending <= 1'b1;
            else if (state == IDLE && vblank)
                pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            move_req <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending && vblank) begin
                        idx   <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (chase_ok[idx]) begin
                        move_req <= ONE << idx;
                        state    <= WAIT_ACK;
                    end else if (last) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                WAIT_ACK: begin
                    if (move_ack[idx]) begin
                        move_req <= '0;
                        if (last || !enable) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GHOST_FACE_TIMER_EN
    localparam logic [25:0] FACE_LAST = 26'(2*FACE_PERIOD - 1);
    localparam logic [25:0] FACE_HALF = 26'(FACE_PERIOD);

    logic [25:0] face_cnt;

    // Free-running; the face animation keeps going while the game is paused.
    always_ff @(posedge clk) begin
        if (reset)
            face_cnt <= '0;
        else if (face_cnt == FACE_LAST)
            face_cnt <= '0;
        else
            face_cnt <= face_cnt + 26'd1;
    end

    assign face_sel = (face_cnt >= FACE_HALF);
`else
    assign face_sel = 1'b0;
`endif

endmodule
